// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, access sizes, FSM states, byte enables.
// MISALIGN_TRAP_EN adds the FAULT state used by the misaligned-access trap.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_ERR,
    ST_FAULT
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE,
    ST_ERR
  } state_e;
`endif

  // Any encoding outside the defined loads/stores falls back to a word access.
  function automatic size_e accessSize(input logic [2:0] f3, input logic isStore);
    size_e sz;
    sz = SZ_WORD;
    if (isStore) begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: shifts the bus word down to the addressed lane and extends it.
module mem_load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  logic        isUnsigned;

  always_comb begin
    shifted    = rdata_i >> {offset_i, 3'b000};
    isUnsigned = funct3_i[2];
    result_o   = shifted;
    case (accessSize(funct3_i, 1'b0))
      SZ_BYTE: result_o = isUnsigned ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = isUnsigned ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// RV32I data-memory access controller bridging the pipeline to a req/ack memory port.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        MisalignFault,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWData,
  input  logic [31:0] BusRData,
  input  logic        BusAck
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  size_e       size_q;
  logic        we_q;

  size_e       size_d;
  logic [31:0] addr_d;
  logic [31:0] loadResult;
  logic        inReq;

  // Low address bits that don't fit the access size are cleared here; in trap mode a
  // difference from the raw address marks the access as misaligned.
  always_comb begin
    size_d = accessSize(funct3, MemWrite);
    addr_d = Addr;
    case (size_d)
      SZ_HALF: addr_d[0]   = 1'b0;
      SZ_WORD: addr_d[1:0] = 2'b00;
      default: addr_d      = Addr;
    endcase
  end

  mem_load_align uLoadAlign (
    .rdata_i  (BusRData),
    .offset_i (addr_q[1:0]),
    .funct3_i (f3_q),
    .result_o (loadResult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      size_q  <= SZ_WORD;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MemRead || MemWrite) begin
            addr_q  <= addr_d;
            wdata_q <= WriteData;
            f3_q    <= funct3;
            size_q  <= size_d;
            we_q    <= MemWrite;
            cnt_q   <= '0;
`ifdef MISALIGN_TRAP_EN
            state_q <= (addr_d != Addr) ? ST_FAULT : ST_REQ;
`else
            state_q <= ST_REQ;
`endif
          end
        end
        ST_REQ: begin
          if (BusAck) begin
            state_q <= ST_DONE;
            if (!we_q) rdata_q <= loadResult;
          end else if (cnt_q == LAST_WAIT) begin
            state_q <= ST_ERR;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign inReq    = (state_q == ST_REQ);
  assign Stall    = inReq || ((state_q == ST_IDLE) && (MemRead || MemWrite));
  assign Done     = (state_q == ST_DONE);
  assign BusErr   = (state_q == ST_ERR);
  assign ReadData = rdata_q;
  assign BusReq   = inReq;
  assign BusWe    = inReq && we_q;
  assign BusAddr  = inReq ? {addr_q[31:2], 2'b00} : 32'd0;

`ifdef MISALIGN_TRAP_EN
  assign MisalignFault = (state_q == ST_FAULT);
`else
  assign MisalignFault = 1'b0;
`endif

  always_comb begin
    BusBe    = 4'b0000;
    BusWData = 32'd0;
    if (inReq) begin
      case (size_q)
        SZ_BYTE: begin
          BusBe    = BE_BYTE << addr_q[1:0];
          BusWData = {4{wdata_q[7:0]}};
        end
        SZ_HALF: begin
          BusBe    = BE_HALF << {addr_q[1], 1'b0};
          BusWData = {2{wdata_q[15:0]}};
        end
        default: begin
          BusBe    = BE_WORD;
          BusWData = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; honours MISALIGN_TRAP_EN for the LHU case.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr, WriteData;
  logic        Stall, Done, MisalignFault, BusErr;
  logic [31:0] ReadData;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusBe;
  logic        BusAck;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .Addr(Addr), .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData), .Done(Done),
    .MisalignFault(MisalignFault), .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe),
    .BusAddr(BusAddr), .BusBe(BusBe), .BusWData(BusWData), .BusRData(BusRData),
    .BusAck(BusAck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    Addr      = a;
    WriteData = wd;
  endtask

  // Zero-wait transaction: request in cycle N, bus phase with ack in N+1, Done in N+2.
  task automatic runAccess(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWData, input logic [31:0] expRead);
    applyStimulus(rd, wr, f3, a, wd);
    BusRData = rdata;
    BusAck   = 1'b0;
    #1;
    checkOutput({tag, ".stallN"}, 32'(Stall), 32'd1);
    checkOutput({tag, ".reqN"}, 32'(BusReq), 32'd0);
    @(negedge clk); #1;
    checkOutput({tag, ".req"}, 32'(BusReq), 32'd1);
    checkOutput({tag, ".addr"}, BusAddr, expAddr);
    checkOutput({tag, ".be"}, 32'(BusBe), 32'(expBe));
    checkOutput({tag, ".we"}, 32'(BusWe), 32'(wr));
    checkOutput({tag, ".wdata"}, BusWData, expWData);
    BusAck = 1'b1;
    @(negedge clk); #1;
    checkOutput({tag, ".done"}, 32'(Done), 32'd1);
    checkOutput({tag, ".stallDone"}, 32'(Stall), 32'd0);
    checkOutput({tag, ".rdata"}, ReadData, expRead);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    BusAck = 1'b0;
    @(negedge clk); #1;
    checkOutput({tag, ".donePulse"}, 32'(Done), 32'd0);
    checkOutput({tag, ".rdataHold"}, ReadData, expRead);
  endtask

  initial begin
    int stallCount, doneCount, reqCount, errCycle;

    rst = 1'b1;
    BusAck = 1'b0;
    BusRData = 32'd0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.stall", 32'(Stall), 32'd0);
    checkOutput("reset.busReq", 32'(BusReq), 32'd0);
    checkOutput("reset.readData", ReadData, 32'd0);
    checkOutput("reset.busBe", 32'(BusBe), 32'd0);
    checkOutput("reset.done", 32'(Done), 32'd0);
    rst = 1'b0;

    // Stray ack while idle must not start anything.
    BusAck = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checkOutput("idleAck.busReq", 32'(BusReq), 32'd0);
    checkOutput("idleAck.done", 32'(Done), 32'd0);
    BusAck = 1'b0;

    runAccess("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80AA_BBCC,
              32'h0000_0100, 4'b1000, 32'd0, 32'hFFFF_FF80);
    runAccess("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'd0, 32'h8765_1234,
              32'h0000_0204, 4'b1100, 32'd0, 32'hFFFF_8765);
    runAccess("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'd0, 32'h0000_9A00,
              32'h0000_0100, 4'b0010, 32'd0, 32'h0000_009A);
    runAccess("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0403, 32'h0000_00A5, 32'hFFFF_FFFF,
              32'h0000_0400, 4'b1000, 32'hA5A5_A5A5, 32'h0000_009A);
    runAccess("sw", 1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'hFFFF_FFFF,
              32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 32'h0000_009A);
    runAccess("rdwr", 1'b1, 1'b1, 3'b000, 32'h0000_0601, 32'h1122_3344, 32'hFFFF_FFFF,
              32'h0000_0600, 4'b0010, 32'h4444_4444, 32'h0000_009A);
    runAccess("f3bad", 1'b1, 1'b0, 3'b111, 32'h0000_0700, 32'd0, 32'h89AB_CDEF,
              32'h0000_0700, 4'b1111, 32'd0, 32'h89AB_CDEF);

    // SH with ack on the third bus cycle.
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    stallCount = 0;
    doneCount  = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      BusAck = (c == 3);
      #1;
      stallCount += int'(Stall);
      doneCount  += int'(Done);
      if (c == 1) begin
        checkOutput("sh.be", 32'(BusBe), 32'h0000_000C);
        checkOutput("sh.wdata", BusWData, 32'hABCD_ABCD);
        checkOutput("sh.addr", BusAddr, 32'h0000_0200);
      end
      if (c == 4) begin
        checkOutput("sh.done", 32'(Done), 32'd1);
        checkOutput("sh.rdataKept", ReadData, 32'h89AB_CDEF);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      end
    end
    checkOutput("sh.stallCycles", 32'(stallCount), 32'd4);
    checkOutput("sh.doneCycles", 32'(doneCount), 32'd1);

    // LW that never gets an ack.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
    BusAck = 1'b0;
    reqCount = 0;
    errCycle = 0;
    for (int i = 1; i <= 40; i++) begin
      if (errCycle == 0) begin
        @(negedge clk); #1;
        reqCount += int'(BusReq);
        if (BusErr) begin
          errCycle = i;
          checkOutput("lwTimeout.rdata", ReadData, 32'd0);
          checkOutput("lwTimeout.stall", 32'(Stall), 32'd0);
          applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        end
      end
    end
    checkOutput("lwTimeout.errCycle", 32'(errCycle), 32'd17);
    checkOutput("lwTimeout.reqCycles", 32'(reqCount), 32'd16);
    @(negedge clk); #1;
    checkOutput("lwTimeout.reqAfter", 32'(BusReq), 32'd0);
    checkOutput("lwTimeout.errPulse", 32'(BusErr), 32'd0);

    // LHU at an odd address.
`ifdef MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'd0);
    BusRData = 32'h1234_F0E1;
    @(negedge clk); #1;
    checkOutput("lhu.fault", 32'(MisalignFault), 32'd1);
    checkOutput("lhu.noReq", 32'(BusReq), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk); #1;
    checkOutput("lhu.faultPulse", 32'(MisalignFault), 32'd0);
    checkOutput("lhu.noReqAfter", 32'(BusReq), 32'd0);
`else
    runAccess("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'd0, 32'h1234_F0E1,
              32'h0000_0100, 4'b0011, 32'd0, 32'h0000_F0E1);
    checkOutput("lhu.noFault", 32'(MisalignFault), 32'd0);
`endif

    // Reset landing on the second bus cycle of an LW.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
    BusAck = 1'b0;
    @(negedge clk); #1;
    checkOutput("rstMid.req1", 32'(BusReq), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    checkOutput("rstMid.req2", 32'(BusReq), 32'd1);
    @(negedge clk); #1;
    checkOutput("rstMid.busReq", 32'(BusReq), 32'd0);
    checkOutput("rstMid.stall", 32'(Stall), 32'd0);
    checkOutput("rstMid.done", 32'(Done), 32'd0);
    checkOutput("rstMid.rdata", ReadData, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("rstMid.doneAfter", 32'(Done), 32'd0);
    checkOutput("rstMid.reqAfter", 32'(BusReq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
